// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- IF-stage sequencer.
//   Owns the fetch PC and drives a req/ready handshake to instruction memory.
//   Presents at most one fetched instruction per cycle to the IF/DE register.
//   Redirects come from decode (predicted taken) and from the branch-not-taken
//   flush, which wins when both are asserted. A one-entry hold buffer absorbs
//   a memory return that lands while IF/DE is stalled.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall                      IF/DE not accepting this cycle
//   redirect_en/redirect_pc    decode predicted-taken target
//   flush_en/flush_pc          misprediction restore (fall-through PC)
//   imem_req/imem_addr         fetch request to memory
//   imem_ready/imem_rdata      memory completion + instruction
//   instr_valid/instr/pc/pc_inc4  IF/DE slot
//   fetch_cnt/stall_cnt        perf counters, present only with FETCH_CTRL_PERF_EN
module fetch_ctrl #(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect_en,
  input  logic [N-1:0] redirect_pc,
  input  logic         flush_en,
  input  logic [N-1:0] flush_pc,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [N-1:0] instr,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_inc4
`ifdef FETCH_CTRL_PERF_EN
  ,output logic [31:0] fetch_cnt
  ,output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DISCARD} state_t;

  state_t       r_state;
  logic [N-1:0] r_fpc;    // next address to fetch (redirect target while discarding)
  logic [N-1:0] r_addr;   // address currently on the bus
  logic         r_req;
  logic         r_valid;
  logic [N-1:0] r_instr;
  logic [N-1:0] r_pc;
  logic [N-1:0] r_pc4;
  logic [N-1:0] r_buf;

  logic         w_redir;
  logic [N-1:0] w_tgt;
  logic         w_free;
  logic         w_load;
  logic [N-1:0] w_ld_data;
  logic [N-1:0] w_fpc4;

  assign w_redir   = flush_en | redirect_en;
  assign w_tgt     = flush_en ? flush_pc : redirect_pc;
  assign w_free    = !r_valid || !stall;
  assign w_fpc4    = r_fpc + N'(4);
  // A redirect suppresses any slot load in the same cycle: that data is stale.
  assign w_load    = !w_redir && w_free &&
                     ((r_state == S_REQ && imem_ready) || r_state == S_HOLD);
  assign w_ld_data = (r_state == S_HOLD) ? r_buf : imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_fpc   <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_buf   <= '0;
    end else begin
      if (r_valid && !stall) r_valid <= 1'b0;
      if (w_load) begin
        r_valid <= 1'b1;
        r_instr <= w_ld_data;
        r_pc    <= r_fpc;
        r_pc4   <= w_fpc4;
        r_fpc   <= w_fpc4;
      end

      if (w_redir) begin
        r_valid <= 1'b0;
        r_fpc   <= w_tgt;
        r_req   <= 1'b1;
        // An outstanding request is never withdrawn: keep its address until
        // the memory completes it, then issue the target.
        if ((r_state == S_REQ || r_state == S_DISCARD) && !imem_ready) begin
          r_state <= S_DISCARD;
        end else begin
          r_state <= S_REQ;
          r_addr  <= w_tgt;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= r_fpc;
          end
          S_REQ: begin
            if (imem_ready) begin
              if (w_free) begin
                r_addr <= w_fpc4;
              end else begin
                r_buf   <= imem_rdata;
                r_state <= S_HOLD;
                r_req   <= 1'b0;
              end
            end
          end
          S_HOLD: begin
            if (w_free) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_addr  <= w_fpc4;
            end
          end
          S_DISCARD: begin
            if (imem_ready) begin
              r_state <= S_REQ;
              r_addr  <= r_fpc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign pc_inc4     = r_pc4;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load)           r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (r_valid && stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. A small memory model answers requests after
// a programmable number of wait cycles and returns addr ^ 32'hC0DE_0000.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        flush_en;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_inc4;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int lat = 0;
  int wcnt = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.N(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .flush_en(flush_en), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_inc4(pc_inc4)
`ifdef FETCH_CTRL_PERF_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_ready = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_ready ? mem(imem_addr) : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wcnt <= 0;
    else if (imem_req && !imem_ready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
  end

  // Holds reset for two cycles and releases it on a falling edge; the cycle
  // that follows is the IDLE cycle.
  task automatic do_reset(input int l);
    rst_n = 1'b0; stall = 1'b0; redirect_en = 1'b0; flush_en = 1'b0;
    redirect_pc = 32'h0; flush_pc = 32'h0; lat = l;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(0);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: req=%b valid=%b, want req=0 valid=0", imem_req, instr_valid);
    end
    checks++;
    if (pc !== 32'h0 || pc_inc4 !== 32'h0 || instr !== 32'h0) begin
      failures++;
      $display("FAIL reset_slot: pc=%h pc4=%h instr=%h, want all 0", pc, pc_inc4, instr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;  // asynchronous: takes effect without a clock edge
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_async: req=%b valid=%b pc=%h, want 0 0 0", imem_req, instr_valid, pc);
    end
  endtask

  task automatic test_stream;
    do_reset(0);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_first: req=%b addr=%h valid=%b, want 1 0 0", imem_req, imem_addr, instr_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_addr !== 32'(4*i) || instr_valid !== 1'b1 || pc !== 32'(4*(i-1)) ||
          instr !== mem(32'(4*(i-1))) || pc_inc4 !== 32'(4*i)) begin
        failures++;
        $display("FAIL stream_%0d: addr=%h valid=%b pc=%h pc4=%h instr=%h, want addr=%h pc=%h",
                 i, imem_addr, instr_valid, pc, pc_inc4, instr, 32'(4*i), 32'(4*(i-1)));
      end
    end
  endtask

  task automatic test_latency;
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL lat_hold_%0d: req=%b addr=%h valid=%b, want 1 0 0", i, imem_req, imem_addr, instr_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h0 || imem_addr !== 32'h4) begin
      failures++;
      $display("FAIL lat_first: valid=%b pc=%h addr=%h, want 1 0 4", instr_valid, pc, imem_addr);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || imem_addr !== 32'h4) begin
        failures++;
        $display("FAIL lat_gap: valid=%b addr=%h, want 0 4", instr_valid, imem_addr);
      end
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h4 || instr !== mem(32'h4)) begin
      failures++;
      $display("FAIL lat_second: valid=%b pc=%h instr=%h, want 1 4 %h", instr_valid, pc, instr, mem(32'h4));
    end
  endtask

  task automatic test_stall;
    do_reset(0);
    repeat (3) @(negedge clk);  // slot now holds pc 4, bus at 8
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'h4 || instr !== mem(32'h4) || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_%0d: valid=%b pc=%h req=%b, want 1 4 0", i, instr_valid, pc, imem_req);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'(8 + 4*i) || instr !== mem(32'(8 + 4*i)) ||
          imem_req !== 1'b1 || imem_addr !== 32'(12 + 4*i)) begin
        failures++;
        $display("FAIL stall_drain_%0d: valid=%b pc=%h req=%b addr=%h, want pc=%h addr=%h",
                 i, instr_valid, pc, imem_req, imem_addr, 32'(8 + 4*i), 32'(12 + 4*i));
      end
    end
  endtask

  task automatic test_redirect;
    do_reset(2);
    @(negedge clk);  // request for 0 outstanding
    redirect_en = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL redir_old_%0d: req=%b addr=%h valid=%b, want 1 0 0", i, imem_req, imem_addr, instr_valid);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL redir_new_%0d: addr=%h valid=%b, want 100 0", i, imem_addr, instr_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h100 || instr !== mem(32'h100)) begin
      failures++;
      $display("FAIL redir_data: valid=%b pc=%h instr=%h, want 1 100 %h", instr_valid, pc, instr, mem(32'h100));
    end
  endtask

  task automatic test_flush_priority;
    do_reset(0);
    repeat (2) @(negedge clk);  // slot holds pc 0
    stall = 1'b1;
    flush_en = 1'b1; flush_pc = 32'h40;
    redirect_en = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    flush_en = 1'b0; redirect_en = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL flush_clear: valid=%b req=%b addr=%h, want 0 1 40", instr_valid, imem_req, imem_addr);
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h40 || instr !== mem(32'h40) || imem_addr !== 32'h44) begin
      failures++;
      $display("FAIL flush_next: valid=%b pc=%h addr=%h, want 1 40 44", instr_valid, pc, imem_addr);
    end
  endtask

  task automatic test_wrap;
    do_reset(0);
    repeat (2) @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_en = 1'b0;
    @(negedge clk);
    @(negedge clk);  // slot pc FFFF_FFFC
    checks++;
    if (pc !== 32'hFFFF_FFFC || pc_inc4 !== 32'h0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pc4: pc=%h pc4=%h addr=%h, want FFFFFFFC 0 0", pc, pc_inc4, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h0 || imem_addr !== 32'h4) begin
      failures++;
      $display("FAIL wrap_next: valid=%b pc=%h addr=%h, want 1 0 4", instr_valid, pc, imem_addr);
    end
  endtask

`ifdef FETCH_CTRL_PERF_EN
  task automatic test_perf;
    do_reset(0);
    checks++;
    if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset: fetch=%0d stall=%0d, want 0 0", fetch_cnt, stall_cnt);
    end
    repeat (3) @(negedge clk);
    stall = 1'b1;
    repeat (4) @(negedge clk);
    stall = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (fetch_cnt !== 32'd10 || stall_cnt !== 32'd4) begin
      failures++;
      $display("FAIL perf_counts: fetch=%0d stall=%0d, want 10 4", fetch_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_stall();
    test_redirect();
    test_flush_priority();
    test_wrap();
`ifdef FETCH_CTRL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the IF stage: owns the fetch PC, drives a request/ready handshake to the instruction memory, and presents one fetched instruction per cycle to the IF/DE pipeline register. It arbitrates between sequential fetch (PC+4), the decode-stage predicted-taken redirect, and the branch-not-taken flush that restores the fall-through PC. It also absorbs hazard-unit stalls with a one-entry hold buffer, so no returned instruction is lost.

## Interface
- `N`, 32, datapath/address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  1  hazard unit: IF/DE not accepting this cycle
- `redirect_en`  in  1  decode predicts branch taken
- `redirect_pc`  in  N  predicted target
- `flush_en`  in  1  misprediction; restore fall-through; beats `redirect_en`
- `flush_pc`  in  N  fall-through PC (LastPC)
- `imem_req`  out  1  fetch request
- `imem_addr`  out  N  fetch address, stable while `imem_req`=1 and `imem_ready`=0
- `imem_ready`  in  1  memory completes request this cycle
- `imem_rdata`  in  N  instruction, valid when `imem_ready`=1
- `instr_valid`  out  1  slot holds a valid instruction
- `instr`  out  N  slot instruction
- `pc`  out  N  address of slot instruction
- `pc_inc4`  out  N  `pc`+4, mod 2^N
- `fetch_cnt`, `stall_cnt`  out  32 each  perf counters, only with `FETCH_CTRL_PERF_EN`

## Operation
- Reset: state IDLE; fetch PC=`RESET_PC`; `imem_req`=0; `instr_valid`=0; `instr`, `pc`, `pc_inc4`, buffer=0.
- Slot free = `!instr_valid || !stall`. Slot consumed when `instr_valid && !stall`.
- States:
  - IDLE: `imem_req`=0. Next cycle -> REQ.
  - REQ: `imem_req`=1, `imem_addr`=fetch PC. On `imem_ready`:
    - slot free: load slot {rdata, fetchPC, fetchPC+4}; fetch PC += 4; stay REQ.
    - slot not free: rdata -> hold buffer; -> HOLD.
  - HOLD: `imem_req`=0. When slot free: buffer -> slot; fetch PC += 4; -> REQ.
  - DISCARD: `imem_req`=1, old address held until `imem_ready`. Data dropped -> REQ.
- Redirect (`flush_en` or `redirect_en`; flush target wins if both):
  - fetch PC <= target; `instr_valid` <= 0 regardless of `stall`; buffer dropped.
  - REQ with `imem_ready`=0 -> DISCARD. The request is never withdrawn.
  - REQ with `imem_ready`=1: data dropped -> REQ.
  - HOLD or IDLE -> REQ.
  - DISCARD: target updated; stay DISCARD.
- PC arithmetic is N-bit wrap: 32'hFFFF_FFFC+4 = 0. No alignment checks.
- `rst_n` low mid-request: immediate return to reset values. The memory side must tolerate an abandoned request.

## Timing
- Memory latency ≥1 cycle. `imem_ready` is sampled with `imem_req`=1; it may be high in the first request cycle.
- `imem_ready` in cycle c -> `instr_valid`/`instr` in c+1.
- With `imem_ready` held high and no stall: one instruction per cycle, addresses increment by 4 each cycle.
- First request: `imem_req`=1 in the second cycle after `rst_n` rises (IDLE cycle first).
- Redirect sampled at edge k: `imem_addr`=target from cycle k+1 if nothing is outstanding. Otherwise the target is issued the cycle after the outstanding `imem_ready`.
- `instr_valid` drops in the cycle after redirect.
- HOLD -> REQ costs one bubble cycle on `imem_req`.

## Configuration
- `FETCH_CTRL_PERF_EN` defined: adds `fetch_cnt` and `stall_cnt`.
  - `fetch_cnt` increments on every slot load.
  - `stall_cnt` increments each cycle with `instr_valid && stall`.
  - Both reset to 0 and wrap at 2^32.
- `FETCH_CTRL_PERF_EN` undefined: ports and logic absent; functional behaviour identical.

## Test plan
- Reset release, `imem_ready`=1 always, no stall -> `imem_addr` 0,4,8,C on consecutive cycles; `instr_valid` from the third cycle; `pc_inc4`=`pc`+4.
- `imem_ready` 3-cycle latency -> `imem_addr` held for 3 cycles; one `instr_valid` per completed request.
- `stall` for 4 cycles during streaming -> slot holds its value; one instruction buffered; `imem_req`=0 in HOLD; on release, instructions emerge in order with none lost or duplicated.
- `redirect_en` with target 32'h100 while a request is outstanding -> old request completes and is dropped; next `imem_addr`=32'h100; `instr_valid`=0 in between.
- `flush_en` (`flush_pc`=32'h40) and `redirect_en` (32'h200) in the same cycle under `stall`=1 -> slot cleared; next fetch is 32'h40.
- Fetch PC 32'hFFFF_FFFC -> next address 0. With `FETCH_CTRL_PERF_EN`, 10 fetches and 4 stall cycles -> `fetch_cnt`=10, `stall_cnt`=4.
